// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   - Default handler vector base and stride.
//   - level_width(): number of bits needed to encode service levels 0..NUM_IRQ.
//   - epc_entry_t: one nesting-stack entry. It holds the return PC and the level
//     that was active before the interrupt was taken.
package irq_pkg;

  localparam int DEF_NUM_IRQ = 3;
  localparam int DEF_ADDR_W  = 32;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_1000;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

  // Level 0 means "no handler active", so NUM_IRQ+1 distinct values are needed.
  function automatic int level_width(input int num_irq);
    return $clog2(num_irq + 1);
  endfunction

  // Field widths follow the controller's default configuration.
  localparam int EPC_W      = DEF_ADDR_W;
  localparam int PREV_LVL_W = level_width(DEF_NUM_IRQ);

  typedef struct packed {
    logic [EPC_W-1:0]      epc;
    logic [PREV_LVL_W-1:0] prev_level;
  } epc_entry_t;

endpackage

// File: rtl/irq_epc_stack.sv
// Parametrised LIFO that holds the nesting context (EPC + previous level).
// Ports:
//   clk, rst         clock and synchronous active-high reset (empties the stack)
//   push, push_data  write a new entry on top; ignored when full
//   pop              discard the top entry; ignored when empty
//   top              current top entry, all-zero when empty
//   empty, full      occupancy flags
// Push takes precedence if both strobes are asserted. The controller never
// asserts them together.
module irq_epc_stack #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign wr_idx = IDX_W'(count);
  assign rd_idx = IDX_W'(count - CNT_W'(1));
  assign top    = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset. count alone decides which entries are
  // live, and top is forced to zero when the stack is empty.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Nested interrupt controller. It turns NUM_IRQ request lines into PC redirects.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   irq_in            raw request lines; a rising edge latches into pending
//   mask_we/_wdata    enable-mask write (1 = enabled)
//   insn_boundary     a PC redirect or ERET may take effect this cycle
//   eret              ERET decoded in the current instruction
//   pc_next           PC to save as EPC when an interrupt is taken
//   take_irq, vec_pc  redirect strobe and handler address (0 when not taking)
//   epc_out           ERET target from the top of the nesting stack (0 if empty)
//   cur_level         level being serviced (0 = none); line i has level i+1
//   pending, mask     latched requests and enable mask
//   nest_full         nesting stack holds NEST_DEPTH entries
//   eret_err          sticky: ERET was executed with an empty stack
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int               NUM_IRQ    = DEF_NUM_IRQ,
  parameter int               NEST_DEPTH = 3,
  parameter int               ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(DEF_VEC_STRIDE),
  localparam int              LVL_W      = level_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               insn_boundary,
  input  logic               eret,
  input  logic [ADDR_W-1:0]  pc_next,
  output logic               take_irq,
  output logic [ADDR_W-1:0]  vec_pc,
  output logic [ADDR_W-1:0]  epc_out,
  output logic [LVL_W-1:0]   cur_level,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic               nest_full,
  output logic               eret_err
);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] take_clr;
  logic [LVL_W-1:0]   level_q;
  logic [LVL_W-1:0]   cand_idx;
  logic [LVL_W-1:0]   cand_lvl;
  logic               cand_valid;
  logic               take;
  logic               do_eret;
  logic               pop;
  logic               eret_err_q;
  logic               stk_empty;
  logic               stk_full;
  epc_entry_t         push_entry;
  epc_entry_t         top_entry;

  // Priority encoder: the highest enabled pending line wins.
  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  // The assignments are blocking, so a later (higher-index) hit overrides an earlier one.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending_q[i] && mask_q[i]) begin
        cand_valid = 1'b1;
        cand_idx   = LVL_W'(i);
      end
    end
  end

  assign cand_lvl = cand_idx + LVL_W'(1);
  assign irq_rise = irq_in & ~irq_q;
  assign do_eret  = eret && insn_boundary;
  assign pop      = do_eret && !stk_empty;

  // ERET in the same cycle blocks the take. The request is re-evaluated
  // against the restored level at the next boundary.
  assign take = insn_boundary && !eret && cand_valid &&
                (cand_lvl > level_q) && !stk_full;

  assign take_clr = take ? (NUM_IRQ'(1) << cand_idx) : '0;

  assign push_entry.epc        = EPC_W'(pc_next);
  assign push_entry.prev_level = PREV_LVL_W'(level_q);

  irq_epc_stack #(
    .DEPTH (NEST_DEPTH),
    .W     ($bits(epc_entry_t))
  ) u_epc_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (take),
    .pop       (pop),
    .push_data (push_entry),
    .top       (top_entry),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  // NOTE: all state uses non-blocking assignments, so every register samples
  // the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q      <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
      level_q    <= '0;
      eret_err_q <= 1'b0;
    end else begin
      irq_q      <= irq_in;
      // OR-ing the new edges in after the clear lets a fresh edge on the bit
      // being taken survive.
      pending_q  <= (pending_q & ~take_clr) | irq_rise;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
      if (take) begin
        level_q <= cand_lvl;
      end else if (pop) begin
        level_q <= LVL_W'(top_entry.prev_level);
      end
      if (do_eret && stk_empty) begin
        eret_err_q <= 1'b1;
      end
    end
  end

  assign take_irq  = take;
  assign vec_pc    = take ? (VEC_BASE + VEC_STRIDE * ADDR_W'(cand_idx)) : '0;
  assign epc_out   = ADDR_W'(top_entry.epc);
  assign cur_level = level_q;
  assign pending   = pending_q;
  assign mask      = mask_q;
  assign nest_full = stk_full;
  assign eret_err  = eret_err_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl (NUM_IRQ=3, NEST_DEPTH=3, VEC_BASE=0x1000,
// VEC_STRIDE=0x10). A behavioural model keeps the pending bits, the mask and a
// queue of nesting frames. Every negedge, the DUT outputs are compared with the
// model. The directed sequence also pins key values with literal expectations.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq_in = '0;
  logic        mask_we = 1'b0;
  logic [2:0]  mask_wdata = '0;
  logic        insn_boundary = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] pc_next = '0;

  logic        take_irq;
  logic [31:0] vec_pc;
  logic [31:0] epc_out;
  logic [1:0]  cur_level;
  logic [2:0]  pending;
  logic [2:0]  mask;
  logic        nest_full;
  logic        eret_err;

  int n_tests = 0;
  int n_fail  = 0;

  irq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .irq_in        (irq_in),
    .mask_we       (mask_we),
    .mask_wdata    (mask_wdata),
    .insn_boundary (insn_boundary),
    .eret          (eret),
    .pc_next       (pc_next),
    .take_irq      (take_irq),
    .vec_pc        (vec_pc),
    .epc_out       (epc_out),
    .cur_level     (cur_level),
    .pending       (pending),
    .mask          (mask),
    .nest_full     (nest_full),
    .eret_err      (eret_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] epc;
    int          lvl;
  } frame_t;

  frame_t     m_stack[$];
  logic [2:0] m_pend  = '0;
  logic [2:0] m_mask  = '1;
  logic [2:0] m_irq_q = '0;
  int         m_level = 0;
  bit         m_err   = 1'b0;
  bit         started = 1'b0;

  function automatic void push_frame(input logic [31:0] e, input int l);
    frame_t f;
    f.epc = e;
    f.lvl = l;
    m_stack.push_back(f);
  endfunction

  // Which line (if any) would be taken with the current model state and inputs.
  task automatic predict(output bit tk, output int id);
    id = -1;
    for (int i = 2; i >= 0; i--) begin
      if (id < 0 && m_pend[i] && m_mask[i]) id = i;
    end
    tk = insn_boundary && !eret && (id >= 0) && (id + 1 > m_level) && (m_stack.size() < 3);
  endtask

  always @(posedge clk) begin : model
    bit tk;
    int id;
    if (rst) begin
      m_pend  <= '0;
      m_mask  <= 3'b111;
      m_irq_q <= '0;
      m_level <= 0;
      m_err   <= 1'b0;
      m_stack.delete();
      started <= 1'b1;
    end else if (started) begin
      predict(tk, id);
      if (tk) begin
        push_frame(pc_next, m_level);
        m_level <= id + 1;
      end else if (eret && insn_boundary) begin
        if (m_stack.size() > 0) begin
          m_level <= m_stack[m_stack.size() - 1].lvl;
          void'(m_stack.pop_back());
        end else begin
          m_err <= 1'b1;
        end
      end
      m_pend  <= (m_pend & ~(tk ? (3'b001 << id) : 3'b000)) | (irq_in & ~m_irq_q);
      m_irq_q <= irq_in;
      if (mask_we) m_mask <= mask_wdata;
    end
  end

  always @(negedge clk) begin : compare
    bit tk;
    int id;
    if (started && !rst) begin
      predict(tk, id);
      check("m.take_irq", take_irq, tk);
      check("m.vec_pc", vec_pc, tk ? 32'(32'h1000 + id * 16) : 32'h0);
      check("m.epc_out", epc_out, (m_stack.size() > 0) ? m_stack[m_stack.size() - 1].epc : 32'h0);
      check("m.cur_level", cur_level, m_level);
      check("m.pending", pending, m_pend);
      check("m.mask", mask, m_mask);
      check("m.nest_full", nest_full, m_stack.size() == 3);
      check("m.eret_err", eret_err, m_err);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    at_neg();
    check("rst.take", take_irq, 0);
    check("rst.vec", vec_pc, 0);
    check("rst.epc", epc_out, 0);
    check("rst.level", cur_level, 0);
    check("rst.mask", mask, 3'b111);
    check("rst.pending", pending, 0);
    check("rst.full", nest_full, 0);
    check("rst.err", eret_err, 0);

    // Basic take
    irq_in = 3'b001; tick(); irq_in = 3'b000;
    insn_boundary = 1'b1; pc_next = 32'h0040_0010;
    at_neg();
    check("basic.pending", pending, 3'b001);
    check("basic.take", take_irq, 1);
    check("basic.vec", vec_pc, 32'h0000_1000);
    tick(); insn_boundary = 1'b0;
    at_neg();
    check("basic.level", cur_level, 1);
    check("basic.pending_clr", pending, 3'b000);
    check("basic.epc", epc_out, 32'h0040_0010);

    // Nesting
    tick(); irq_in = 3'b100; tick(); irq_in = 3'b000;
    insn_boundary = 1'b1; pc_next = 32'h0000_1004;
    at_neg();
    check("nest.take", take_irq, 1);
    check("nest.vec", vec_pc, 32'h0000_1020);
    tick(); insn_boundary = 1'b0;
    at_neg();
    check("nest.level", cur_level, 3);
    check("nest.epc", epc_out, 32'h0000_1004);

    // Deferred lower priority, ERET unwinding
    tick(); irq_in = 3'b010; tick(); irq_in = 3'b000; insn_boundary = 1'b1;
    at_neg();
    check("defer.pending", pending, 3'b010);
    check("defer.no_take", take_irq, 0);
    tick(); eret = 1'b1;
    at_neg();
    check("eret1.epc", epc_out, 32'h0000_1004);
    check("eret1.no_take", take_irq, 0);
    tick(); eret = 1'b0; pc_next = 32'h0000_2000;
    at_neg();
    check("eret1.level", cur_level, 1);
    check("defer.take", take_irq, 1);
    check("defer.vec", vec_pc, 32'h0000_1010);
    tick(); eret = 1'b1;
    at_neg();
    check("defer.level", cur_level, 2);
    check("defer.epc", epc_out, 32'h0000_2000);
    tick();
    at_neg();
    check("eret2.level", cur_level, 1);
    check("eret2.epc", epc_out, 32'h0040_0010);
    tick(); eret = 1'b0; insn_boundary = 1'b0;
    at_neg();
    check("eret3.level", cur_level, 0);
    check("eret3.epc", epc_out, 0);

    // Mask
    tick(); mask_we = 1'b1; mask_wdata = 3'b011; tick(); mask_we = 1'b0;
    at_neg();
    check("mask.value", mask, 3'b011);
    irq_in = 3'b100; tick(); irq_in = 3'b000; insn_boundary = 1'b1;
    at_neg();
    check("mask.pending", pending, 3'b100);
    check("mask.no_take", take_irq, 0);
    tick(); mask_we = 1'b1; mask_wdata = 3'b111;
    at_neg();
    check("mask.wr_cycle_no_take", take_irq, 0);
    tick(); mask_we = 1'b0;
    at_neg();
    check("mask.take", take_irq, 1);
    check("mask.vec", vec_pc, 32'h0000_1020);
    tick(); insn_boundary = 1'b0;
    at_neg();
    check("mask.level", cur_level, 3);
    tick(); eret = 1'b1; insn_boundary = 1'b1; tick(); eret = 1'b0; insn_boundary = 1'b0;
    at_neg();
    check("mask.unwind", cur_level, 0);

    // ERET on empty stack
    tick(); eret = 1'b1; insn_boundary = 1'b1;
    at_neg();
    check("empty.epc", epc_out, 0);
    tick(); eret = 1'b0; insn_boundary = 1'b0;
    at_neg();
    check("empty.err", eret_err, 1);
    check("empty.level", cur_level, 0);
    repeat (3) tick();
    at_neg();
    check("empty.err_sticky", eret_err, 1);

    // ERET hold-off, then set-wins on the bit being taken
    tick(); irq_in = 3'b001; tick(); irq_in = 3'b000; eret = 1'b1; insn_boundary = 1'b1;
    at_neg();
    check("hold.eret_pending", pending, 3'b001);
    check("hold.eret_no_take", take_irq, 0);
    tick(); eret = 1'b0; irq_in = 3'b001; pc_next = 32'h0000_3000;
    at_neg();
    check("hold.take", take_irq, 1);
    check("hold.vec", vec_pc, 32'h0000_1000);
    tick(); irq_in = 3'b000; insn_boundary = 1'b0;
    at_neg();
    check("setwins.pending", pending, 3'b001);
    check("setwins.level", cur_level, 1);
    check("setwins.epc", epc_out, 32'h0000_3000);

    // No boundary for 5 cycles
    irq_in = 3'b010; tick(); irq_in = 3'b000;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      check("noboundary.no_take", take_irq, 0);
      tick();
    end
    insn_boundary = 1'b1; pc_next = 32'h0000_3100;
    at_neg();
    check("noboundary.take", take_irq, 1);
    check("noboundary.vec", vec_pc, 32'h0000_1010);
    tick(); insn_boundary = 1'b0;
    at_neg();
    check("noboundary.level", cur_level, 2);

    // Fill the stack
    irq_in = 3'b100; tick(); irq_in = 3'b000; insn_boundary = 1'b1; pc_next = 32'h0000_3200;
    at_neg();
    check("full.take", take_irq, 1);
    tick();
    at_neg();
    check("full.flag", nest_full, 1);
    check("full.level", cur_level, 3);
    check("full.no_take", take_irq, 0);
    tick(); irq_in = 3'b111; tick(); irq_in = 3'b000;
    at_neg();
    check("full.pending", pending, 3'b111);
    check("full.blocked", take_irq, 0);
    tick(); eret = 1'b1; tick(); eret = 1'b0;
    at_neg();
    check("full.after_eret_level", cur_level, 2);
    check("full.retake", take_irq, 1);
    check("full.retake_vec", vec_pc, 32'h0000_1020);
    tick(); insn_boundary = 1'b0;
    at_neg();
    check("full.again", nest_full, 1);

    // Reset mid-service with a line held high through reset
    tick(); irq_in = 3'b100; rst = 1'b1;
    tick(); tick(); rst = 1'b0;
    at_neg();
    check("midrst.level", cur_level, 0);
    check("midrst.epc", epc_out, 0);
    check("midrst.full", nest_full, 0);
    check("midrst.pending", pending, 3'b000);
    check("midrst.err", eret_err, 0);
    tick();
    at_neg();
    check("midrst.one_pending", pending, 3'b100);
    tick(); tick();
    at_neg();
    check("midrst.still_one", pending, 3'b100);
    irq_in = 3'b000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller next to the instruction decoder; turns NUM_IRQ external request lines into PC redirects for the datapath.
- Edge-detects and latches requests, masks them, and selects the highest-priority request above the current service level.
- Saves the return PC on a nesting stack and restores it on ERET.
- Supports nested interrupts up to NEST_DEPTH levels, where the current single-level controller supports none.

Parameters:
- NUM_IRQ, 3, number of request lines; line i has priority level i+1, and a higher index means higher priority.
- NEST_DEPTH, 3, maximum number of simultaneously active handlers (EPC stack entries).
- ADDR_W, 32, PC width.
- VEC_BASE, 32'h0000_1000, handler address for line 0.
- VEC_STRIDE, 32'h0000_0010, address spacing between handler vectors.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  raw request lines, synchronous to clk.
- mask_we  in  1  write strobe for the enable mask.
- mask_wdata  in  NUM_IRQ  new mask value; 1 means enabled.
- insn_boundary  in  1  the current instruction may be interrupted or retired; PC redirect is legal in this cycle.
- eret  in  1  ERET decoded in the current instruction.
- pc_next  in  ADDR_W  PC that would execute next; saved as EPC when an interrupt is taken.
- take_irq  out  1  redirect PC to vec_pc in this cycle.
- vec_pc  out  ADDR_W  handler address; 0 when take_irq=0.
- epc_out  out  ADDR_W  top-of-stack EPC (ERET target); 0 when the stack is empty.
- cur_level  out  clog2(NUM_IRQ+1)  level being serviced; 0 means none.
- pending  out  NUM_IRQ  latched requests.
- mask  out  NUM_IRQ  current enable mask.
- nest_full  out  1  stack holds NEST_DEPTH entries.
- eret_err  out  1  sticky flag: ERET was executed with an empty stack.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - pending=0, cur_level=0, stack empty, mask all-ones, eret_err=0.
  - irq_in history register irq_q = 0, so a line held high through reset produces exactly one pending request.
  - All outputs derive from this state, so take_irq=0, vec_pc=0, epc_out=0, nest_full=0.
- Edge detection: pending[i] is set on the edge after irq_in[i] & ~irq_q[i].
  - If a set and a clear (take) hit the same bit in one cycle, set wins.
- Candidate selection (combinational): idx = highest i with pending[i] & mask[i]; cand_lvl = idx+1.
- take_irq = insn_boundary & ~eret & candidate exists & cand_lvl > cur_level & ~nest_full. It is combinational from registered state plus inputs.
- On the clk edge where take_irq=1:
  - push {pc_next, cur_level} onto the stack;
  - cur_level <= cand_lvl;
  - pending[idx] <= 0.
- vec_pc = VEC_BASE + idx*VEC_STRIDE, computed modulo 2^ADDR_W.
- ERET (eret & insn_boundary):
  - Stack non-empty: epc_out is valid in that same cycle; on the edge, pop and restore cur_level from the popped entry.
  - Stack empty: no state change except eret_err <= 1.
- eret with insn_boundary=0 is ignored.
- ERET and a take-eligible request in the same cycle: ERET wins. The request stays pending and is re-evaluated from the next boundary against the restored level.
- Lower/equal-priority requests during service: they stay pending and are taken after ERET lowers cur_level.
- Masked requests still latch into pending but are never taken; unmasking makes them eligible the cycle after the mask_we edge.
- Stack full: no take regardless of priority; requests stay pending.
- No latency beyond: edge→pending 1 cycle; pending→take at the first eligible boundary, same cycle.
- rst asserted mid-service: all nesting state is discarded; no EPC is retained.

Decomposition:
- Shared package irq_pkg holds:
  - default VEC_BASE and VEC_STRIDE;
  - the level-width function (clog2(NUM_IRQ+1));
  - the EPC stack entry struct {epc, prev_level}.
- One sub-module, irq_epc_stack:
  - parametrised LIFO (DEPTH, entry width);
  - push/pop/top/empty/full;
  - pop on empty is a no-op.
- The priority encoder stays inline.

Test Plan:
All cases use NUM_IRQ=3, NEST_DEPTH=3, VEC_BASE=0x1000, VEC_STRIDE=0x10.
- Basic take: after reset, pulse irq_in[0], then insn_boundary=1, pc_next=0x0040_0010 → take_irq=1, vec_pc=0x1000; next cycle cur_level=1, pending=000, epc_out=0x0040_0010.
- Nesting: at level 1, edge on irq_in[2], pc_next=0x1004 → vec_pc=0x1020, cur_level=3. ERET → epc_out=0x1004, cur_level back to 1. Second ERET → epc_out=0x0040_0010, cur_level=0.
- Deferred lower priority: at level 3, edge on irq_in[1] → pending=010, take_irq=0. ERET to level 1 → irq 1 taken at the next boundary, vec_pc=0x1010.
- Mask: write mask_wdata=011, then edge on irq_in[2] → pending=100, no take. Write mask=111 → take on the following boundary, vec_pc=0x1020.
- ERET on empty stack: eret=1, insn_boundary=1 → state unchanged, eret_err=1 and it stays 1 until rst.
- Hold-offs:
  - eret=1 with irq[0] pending → no take that cycle; take happens on the next boundary.
  - insn_boundary=0 for 5 cycles with a pending request → take_irq stays 0 throughout.
  - Reaching nest_full=1 blocks every further take.
